// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline control unit.
// Build option used by pipeline_ctrl: PIPELINE_CTRL_FORWARDING_EN.
package pipeline_ctrl_pkg;

   // Widest configuration supported; narrower builds zero-extend into these types.
   localparam int MAX_FWD_STAGES = 4;
   localparam int MAX_REG_AW     = 8;
   localparam int FWD_SEL_W      = $clog2(MAX_FWD_STAGES + 1);

   typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

   typedef struct packed {
      logic                  valid;
      logic [MAX_REG_AW-1:0] rd;
      logic                  wr;
      logic                  is_load;
   } sb_entry_t;

   // Pipeline register indices for pipe_load / pipe_rst.
   localparam int IFID  = 0;
   localparam int IDEX  = 1;
   localparam int EXMEM = 2;
   localparam int MEMWB = 3;

   // Returns k of the lowest set match bit (k = bit index + 1), 0 when none is set.
   function automatic fwd_sel_t youngest_match(input logic [MAX_FWD_STAGES-1:0] match);
      fwd_sel_t sel;
      sel = '0;
      for (int k = MAX_FWD_STAGES; k >= 1; k--) begin
         if (match[k-1]) begin
            sel = fwd_sel_t'(k);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_scoreboard.sv
// Shadow scoreboard of in-flight destination registers.
// Entry index 0 mirrors ID/EX (stage 1); higher indices are older stages.
// Produces per-entry match vectors for the two ID source registers.
module hazard_scoreboard
   import pipeline_ctrl_pkg::*;
#(
   parameter int NUM_FWD_STAGES = 3,
   parameter int REG_AW         = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      advance,
   input  logic                      bubble,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_load_regfile,
   input  logic                      id_is_load,
   input  logic [REG_AW-1:0]         id_rs1,
   input  logic [REG_AW-1:0]         id_rs2,
   input  logic                      id_use_rs1,
   input  logic                      id_use_rs2,
   output logic [NUM_FWD_STAGES-1:0] rs1_match,
   output logic [NUM_FWD_STAGES-1:0] rs2_match,
   output logic                      head_is_load
);

   sb_entry_t entries [NUM_FWD_STAGES];
   sb_entry_t id_entry;

   // Build the record that enters stage 1: the ID instruction, or a bubble.
   always_comb begin
      id_entry = '0;
      if (!bubble) begin
         id_entry.valid   = 1'b1;
         id_entry.rd      = MAX_REG_AW'(id_rd);
         id_entry.wr      = id_load_regfile;
         id_entry.is_load = id_is_load;
      end
   end

   // Shift the scoreboard on advance cycles; the oldest entry falls off the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_FWD_STAGES; k++) begin
            entries[k] <= '0;
         end
      end else if (advance) begin
         entries[0] <= id_entry;
         for (int k = 1; k < NUM_FWD_STAGES; k++) begin
            entries[k] <= entries[k-1];
         end
      end
   end

   // A stage matches a used source when it writes that register and it is not x0.
   always_comb begin
      rs1_match = '0;
      rs2_match = '0;
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
         rs1_match[k] = id_use_rs1 & entries[k].valid & entries[k].wr
                        & (entries[k].rd == MAX_REG_AW'(id_rs1)) & (id_rs1 != '0);
         rs2_match[k] = id_use_rs2 & entries[k].valid & entries[k].wr
                        & (entries[k].rd == MAX_REG_AW'(id_rs2)) & (id_rs2 != '0);
      end
   end

   assign head_is_load = entries[0].is_load;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit for the five-stage RV32I core: forwarding selects,
// load-use interlock, memory stalls, branch flushes and a stall counter.
// Build option: PIPELINE_CTRL_FORWARDING_EN enables operand forwarding;
// without it the selects stay 0 and any in-flight writer interlocks.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int NUM_FWD_STAGES = 3,
   parameter int REG_AW         = 5,
   parameter int CNT_W          = 32
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [REG_AW-1:0]                     id_rs1,
   input  logic [REG_AW-1:0]                     id_rs2,
   input  logic                                  id_use_rs1,
   input  logic                                  id_use_rs2,
   input  logic [REG_AW-1:0]                     id_rd,
   input  logic                                  id_load_regfile,
   input  logic                                  id_is_load,
   input  logic                                  imem_stall,
   input  logic                                  dmem_stall,
   input  logic                                  ex_br_taken,
   output logic [$clog2(NUM_FWD_STAGES+1)-1:0]   rs1mux_sel,
   output logic [$clog2(NUM_FWD_STAGES+1)-1:0]   rs2mux_sel,
   output logic                                  pc_load,
   output logic [3:0]                            pipe_load,
   output logic [3:0]                            pipe_rst,
   output logic [CNT_W-1:0]                      stall_cycles
);

   localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

   logic [NUM_FWD_STAGES-1:0] rs1_match;
   logic [NUM_FWD_STAGES-1:0] rs2_match;
   logic                      head_is_load;
   logic                      mem_stall;
   logic                      flush;
   logic                      interlock;
   logic                      advance;
   logic                      bubble;

   assign mem_stall = imem_stall | dmem_stall;
   assign flush     = ex_br_taken;
   assign advance   = ~mem_stall;
   assign bubble    = flush | interlock;

   hazard_scoreboard #(
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .REG_AW         (REG_AW)
   ) u_scoreboard (
      .clk             (clk),
      .rst_n           (rst_n),
      .advance         (advance),
      .bubble          (bubble),
      .id_rd           (id_rd),
      .id_load_regfile (id_load_regfile),
      .id_is_load      (id_is_load),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .rs1_match       (rs1_match),
      .rs2_match       (rs2_match),
      .head_is_load    (head_is_load)
   );

`ifdef PIPELINE_CTRL_FORWARDING_EN
   // Only a load still in EX cannot be forwarded; everything older comes off a bypass.
   assign interlock  = head_is_load & (rs1_match[0] | rs2_match[0]);
   assign rs1mux_sel = rst_n ? SEL_W'(youngest_match(MAX_FWD_STAGES'(rs1_match))) : '0;
   assign rs2mux_sel = rst_n ? SEL_W'(youngest_match(MAX_FWD_STAGES'(rs2_match))) : '0;
`else
   // No bypass network and no regfile write-through: any tracked writer blocks ID,
   // loads included, so the load flag is not needed here.
   logic unused_head_is_load;
   assign unused_head_is_load = head_is_load;
   assign interlock  = (|rs1_match) | (|rs2_match);
   assign rs1mux_sel = '0;
   assign rs2mux_sel = '0;
`endif

   // Priority: reset > memory stall > flush > interlock > normal advance.
   always_comb begin
      pc_load          = 1'b1;
      pipe_load[IFID]  = 1'b1;
      pipe_load[IDEX]  = 1'b1;
      pipe_load[EXMEM] = 1'b1;
      pipe_load[MEMWB] = 1'b1;
      pipe_rst         = '0;
      if (!rst_n) begin
         pc_load   = 1'b0;
         pipe_load = '0;
         pipe_rst  = 4'b1111;
      end else if (mem_stall) begin
         pc_load   = 1'b0;
         pipe_load = '0;
      end else if (flush) begin
         pipe_rst[IFID] = 1'b1;
         pipe_rst[IDEX] = 1'b1;
      end else if (interlock) begin
         pc_load         = 1'b0;
         pipe_load[IFID] = 1'b0;
         pipe_rst[IDEX]  = 1'b1;
      end
   end

   // Count every cycle the PC is held, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (!pc_load && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: scripted vector tables, multi-cycle
// corner sequences and a randomized run against a queue-based reference model.
// Expectations follow PIPELINE_CTRL_FORWARDING_EN when it is defined.
module tb_pipeline_ctrl;

   localparam int NFS = 3;
   localparam int RAW = 5;
   localparam int CW  = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

`ifdef PIPELINE_CTRL_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // Expected-response kinds: normal, interlock, memory stall, flush, reset.
   localparam int KN = 0;
   localparam int KS = 1;
   localparam int KM = 2;
   localparam int KF = 3;
   localparam int KR = 4;

   typedef struct packed {
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } instr_t;

   typedef struct {
      instr_t     ins;
      logic       im;
      logic       dm;
      logic       br;
      logic [1:0] s1;
      logic [1:0] s2;
      int         kind;
   } vec_t;

   typedef struct {
      bit valid;
      int rd;
      bit wr;
      bit ld;
   } writer_t;

   logic           clk;
   logic           rst_n;
   logic [RAW-1:0] id_rs1, id_rs2, id_rd;
   logic           id_use_rs1, id_use_rs2, id_load_regfile, id_is_load;
   logic           imem_stall, dmem_stall, ex_br_taken;
   logic [1:0]     rs1mux_sel, rs2mux_sel;
   logic           pc_load;
   logic [3:0]     pipe_load, pipe_rst;
   logic [CW-1:0]  stall_cycles;

   int passes = 0;
   int total  = 0;

   vec_t    rows [$];
   writer_t inflight [$];
   int      model_cnt;

   instr_t nop, lw_x5, add_x6, add_x5, sub_x7, add_x0, sub_x7_x0, add_x5b, rd_x5;
   logic [1:0] f1, f2;

   pipeline_ctrl #(
      .NUM_FWD_STAGES (NFS),
      .REG_AW         (RAW),
      .CNT_W          (CW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .id_rd           (id_rd),
      .id_load_regfile (id_load_regfile),
      .id_is_load      (id_is_load),
      .imem_stall      (imem_stall),
      .dmem_stall      (dmem_stall),
      .ex_br_taken     (ex_br_taken),
      .rs1mux_sel      (rs1mux_sel),
      .rs2mux_sel      (rs2mux_sel),
      .pc_load         (pc_load),
      .pipe_load       (pipe_load),
      .pipe_rst        (pipe_rst),
      .stall_cycles    (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic instr_t mki(input int rs1, input bit u1, input int rs2, input bit u2,
                                  input int rd, input bit wr, input bit ld);
      instr_t i;
      i.rs1 = 5'(rs1); i.u1 = u1; i.rs2 = 5'(rs2); i.u2 = u2;
      i.rd  = 5'(rd);  i.wr = wr; i.ld  = ld;
      return i;
   endfunction

   function automatic vec_t mv(input instr_t i, input logic im, input logic dm, input logic br,
                               input logic [1:0] s1, input logic [1:0] s2, input int kind);
      vec_t v;
      v.ins = i; v.im = im; v.dm = dm; v.br = br;
      v.s1 = s1; v.s2 = s2; v.kind = kind;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      id_rs1 = v.ins.rs1; id_use_rs1 = v.ins.u1;
      id_rs2 = v.ins.rs2; id_use_rs2 = v.ins.u2;
      id_rd  = v.ins.rd;  id_load_regfile = v.ins.wr; id_is_load = v.ins.ld;
      imem_stall = v.im; dmem_stall = v.dm; ex_br_taken = v.br;
   endtask

   task automatic checkOutput(input string name, input vec_t v);
      logic        pc_e;
      logic [3:0]  pl_e, pr_e;
      logic [12:0] act, exp;
      case (v.kind)
         KN:      begin pc_e = 1'b1; pl_e = 4'hF; pr_e = 4'h0; end
         KS:      begin pc_e = 1'b0; pl_e = 4'hE; pr_e = 4'h2; end
         KM:      begin pc_e = 1'b0; pl_e = 4'h0; pr_e = 4'h0; end
         KF:      begin pc_e = 1'b1; pl_e = 4'hF; pr_e = 4'h3; end
         default: begin pc_e = 1'b0; pl_e = 4'h0; pr_e = 4'hF; end
      endcase
      exp = {v.s1, v.s2, pc_e, pl_e, pr_e};
      act = {rs1mux_sel, rs2mux_sel, pc_load, pipe_load, pipe_rst};
      total++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got sel1=%0d sel2=%0d pc_load=%b pipe_load=%b pipe_rst=%b, expected sel1=%0d sel2=%0d pc_load=%b pipe_load=%b pipe_rst=%b",
                    name, rs1mux_sel, rs2mux_sel, pc_load, pipe_load, pipe_rst,
                    v.s1, v.s2, pc_e, pl_e, pr_e);
   endtask

   task automatic checkCount(input string name, input int exp);
      total++;
      if (int'(stall_cycles) == exp) passes++;
      else $display("[TB] FAIL %s: stall_cycles got %0d, expected %0d", name, stall_cycles, exp);
   endtask

   // One clock of stimulus: drive, compare mid-cycle, then cross the rising edge.
   task automatic applyStimulus(input string name, input vec_t v);
      drive(v);
      #2;
      checkOutput(name, v);
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      writer_t w;
      w = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
      inflight.delete();
      for (int k = 0; k < NFS; k++) inflight.push_back(w);
      model_cnt = 0;
   endtask

   task automatic doReset(input string name);
      rst_n = 1'b0;
      drive(mv(nop, 0, 0, 0, 0, 0, KR));
      #1;
      checkOutput({name, "_outputs"}, mv(nop, 0, 0, 0, 0, 0, KR));
      checkCount({name, "_count"}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic runRows(input string tag);
      for (int i = 0; i < rows.size(); i++) begin
         applyStimulus($sformatf("%s[%0d]", tag, i), rows[i]);
      end
      rows.delete();
   endtask

   task automatic pushDrain();
      for (int i = 0; i < NFS; i++) rows.push_back(mv(nop, 0, 0, 0, 0, 0, KN));
   endtask

   task automatic pushRepeat(input vec_t v, input int n);
      for (int i = 0; i < n; i++) rows.push_back(v);
   endtask

   function automatic bit writes(input writer_t w, input int src);
      return w.valid && w.wr && (src != 0) && (w.rd == src);
   endfunction

   initial begin
      instr_t ri;
      logic   im, dm, br;
      int     sel1, sel2, kind;
      bit     any, head_hit;
      writer_t nw;

      nop       = mki(0, 0, 0, 0, 0, 0, 0);
      lw_x5     = mki(2, 1, 0, 0, 5, 1, 1);
      add_x6    = mki(5, 1, 1, 1, 6, 1, 0);
      add_x5    = mki(1, 1, 2, 1, 5, 1, 0);
      sub_x7    = mki(5, 1, 5, 1, 7, 1, 0);
      add_x0    = mki(1, 1, 2, 1, 0, 1, 0);
      sub_x7_x0 = mki(0, 1, 0, 1, 7, 1, 0);
      add_x5b   = mki(3, 1, 4, 1, 5, 1, 0);
      rd_x5     = mki(5, 1, 5, 0, 9, 1, 0);
      f1 = FWD ? 2'd1 : 2'd0;
      f2 = FWD ? 2'd2 : 2'd0;

      doReset("reset0");

      // Scripted scenarios, each followed by enough bubbles to empty the scoreboard.
`ifdef PIPELINE_CTRL_FORWARDING_EN
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(add_x6, 0, 0, 0, 1, 0, KS));
      rows.push_back(mv(add_x6, 0, 0, 0, 2, 0, KN));
      pushDrain();
      rows.push_back(mv(add_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(sub_x7, 0, 0, 0, 1, 1, KN));
      pushDrain();
      rows.push_back(mv(add_x0, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(sub_x7_x0, 0, 0, 0, 0, 0, KN));
      pushDrain();
      rows.push_back(mv(add_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(add_x5b, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(rd_x5, 0, 0, 0, 1, 0, KN));
      pushDrain();
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(add_x6, 0, 0, 1, 1, 0, KF));
      rows.push_back(mv(nop, 0, 0, 0, 0, 0, KN));
      pushDrain();
      rows.push_back(mv(add_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(sub_x7, 1, 0, 0, 1, 1, KM));
      rows.push_back(mv(sub_x7, 1, 0, 1, 1, 1, KM));
      rows.push_back(mv(sub_x7, 0, 0, 0, 1, 1, KN));
      pushDrain();
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      pushRepeat(mv(add_x6, 0, 1, 0, 1, 0, KM), 2);
      rows.push_back(mv(add_x6, 0, 0, 0, 1, 0, KS));
      rows.push_back(mv(add_x6, 0, 0, 0, 2, 0, KN));
      pushDrain();
`else
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      pushRepeat(mv(add_x6, 0, 0, 0, 0, 0, KS), 3);
      rows.push_back(mv(add_x6, 0, 0, 0, 0, 0, KN));
      pushDrain();
      rows.push_back(mv(add_x5, 0, 0, 0, 0, 0, KN));
      pushRepeat(mv(sub_x7, 0, 0, 0, 0, 0, KS), 3);
      rows.push_back(mv(sub_x7, 0, 0, 0, 0, 0, KN));
      pushDrain();
      rows.push_back(mv(add_x0, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(sub_x7_x0, 0, 0, 0, 0, 0, KN));
      pushDrain();
      rows.push_back(mv(add_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(add_x5b, 0, 0, 0, 0, 0, KN));
      pushRepeat(mv(rd_x5, 0, 0, 0, 0, 0, KS), 3);
      rows.push_back(mv(rd_x5, 0, 0, 0, 0, 0, KN));
      pushDrain();
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(add_x6, 0, 0, 1, 0, 0, KF));
      rows.push_back(mv(nop, 0, 0, 0, 0, 0, KN));
      pushDrain();
      rows.push_back(mv(add_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(sub_x7, 1, 0, 0, 0, 0, KM));
      rows.push_back(mv(sub_x7, 1, 0, 1, 0, 0, KM));
      pushRepeat(mv(sub_x7, 0, 0, 0, 0, 0, KS), 3);
      rows.push_back(mv(sub_x7, 0, 0, 0, 0, 0, KN));
      pushDrain();
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      pushRepeat(mv(add_x6, 0, 1, 0, 0, 0, KM), 2);
      pushRepeat(mv(add_x6, 0, 0, 0, 0, 0, KS), 3);
      rows.push_back(mv(add_x6, 0, 0, 0, 0, 0, KN));
      pushDrain();
`endif
      runRows("table");

      // Load-use back-to-back: stall count after the dependent add resolves.
      doReset("reset_lu");
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(add_x6, 0, 0, 0, f1, 0, KS));
      if (FWD) rows.push_back(mv(add_x6, 0, 0, 0, f2, 0, KN));
      else begin
         pushRepeat(mv(add_x6, 0, 0, 0, 0, 0, KS), 2);
         rows.push_back(mv(add_x6, 0, 0, 0, 0, 0, KN));
      end
      runRows("loaduse");
      checkCount("loaduse_count", FWD ? 1 : 3);

      // Data-cache miss held five cycles over a pending load-use.
      doReset("reset_dm");
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      pushRepeat(mv(add_x6, 0, 1, 0, f1, 0, KM), 5);
      rows.push_back(mv(add_x6, 0, 0, 0, f1, 0, KS));
      if (FWD) rows.push_back(mv(add_x6, 0, 0, 0, f2, 0, KN));
      else begin
         pushRepeat(mv(add_x6, 0, 0, 0, 0, 0, KS), 2);
         rows.push_back(mv(add_x6, 0, 0, 0, 0, 0, KN));
      end
      runRows("dmem");
      checkCount("dmem_count", FWD ? 6 : 8);

      // Flush coincident with a load-use hazard records no stall.
      doReset("reset_br");
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      rows.push_back(mv(add_x6, 0, 0, 1, f1, 0, KF));
      rows.push_back(mv(nop, 0, 0, 0, 0, 0, KN));
      runRows("flush_lu");
      checkCount("flush_lu_count", 0);

      // Reset asserted in the middle of an interlock cycle.
      doReset("reset_mid");
      pushRepeat(mv(nop, 1, 0, 0, 0, 0, KM), 2);
      rows.push_back(mv(lw_x5, 0, 0, 0, 0, 0, KN));
      runRows("pre_mid");
      drive(mv(add_x6, 0, 0, 0, f1, 0, KS));
      #2;
      checkOutput("mid_stall", mv(add_x6, 0, 0, 0, f1, 0, KS));
      checkCount("mid_stall_count", 2);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset", mv(add_x6, 0, 0, 0, 0, 0, KR));
      checkCount("mid_reset_count", 0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      checkOutput("post_reset", mv(add_x6, 0, 0, 0, 0, 0, KN));
      @(posedge clk);
      #1;
      checkCount("post_reset_count", 0);

      // Counter saturation with a narrow counter.
      doReset("reset_sat");
      pushRepeat(mv(nop, 1, 0, 0, 0, 0, KM), CNT_MAX - 1);
      runRows("sat_a");
      checkCount("sat_below", CNT_MAX - 1);
      pushRepeat(mv(nop, 0, 1, 0, 0, 0, KM), 6);
      runRows("sat_b");
      checkCount("sat_hold", CNT_MAX);

      // Randomized traffic against the reference model.
      doReset("reset_rand");
      for (int c = 0; c < 400; c++) begin
         ri = mki($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
         ri.ld = ri.wr & ($urandom_range(0, 2) == 0);
         im = ($urandom_range(0, 9) == 0);
         dm = ($urandom_range(0, 9) == 0);
         br = ($urandom_range(0, 7) == 0);

         sel1 = 0; sel2 = 0; any = 1'b0;
         for (int k = 0; k < NFS; k++) begin
            if (ri.u1 && writes(inflight[k], int'(ri.rs1))) begin
               any = 1'b1;
               if (sel1 == 0) sel1 = k + 1;
            end
            if (ri.u2 && writes(inflight[k], int'(ri.rs2))) begin
               any = 1'b1;
               if (sel2 == 0) sel2 = k + 1;
            end
         end
         head_hit = (ri.u1 && writes(inflight[0], int'(ri.rs1))) ||
                    (ri.u2 && writes(inflight[0], int'(ri.rs2)));
         if (FWD) any = inflight[0].ld && head_hit;
         else begin
            sel1 = 0;
            sel2 = 0;
         end
         kind = (im || dm) ? KM : br ? KF : any ? KS : KN;

         checkCount($sformatf("rand_count[%0d]", c), model_cnt);
         applyStimulus($sformatf("rand[%0d]", c),
                       mv(ri, im, dm, br, 2'(sel1), 2'(sel2), kind));

         if (!(im || dm)) begin
            if (br || any) nw = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
            else nw = '{valid: 1'b1, rd: int'(ri.rd), wr: ri.wr, ld: ri.ld};
            void'(inflight.pop_back());
            inflight.push_front(nw);
         end
         if ((kind == KS || kind == KM) && model_cnt < CNT_MAX) model_cnt++;
      end
      checkCount("rand_final_count", model_cnt);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
